tdm_demux1_16: RTL and testbench

- Sequential 1-to-16 time-division demultiplexer. It is the receive end of our 16:1 mux serializer, which drives channel Ik when select S3..S0 = k.
- Accepts one serial slot per valid beat and tracks the slot index with a 4-bit counter, aligned by a frame-sync marker on slot 0.
- Assembles 16 channels in a shadow register and publishes the complete frame on a registered parallel output with a one-cycle frame strobe.
- Sits between the serial link and the parallel channel consumers.

---
 rtl/tdm_demux1_16.sv | 92 +++++++++
 tb/tb_tdm_demux1_16.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tdm_demux1_16.sv
// Receive side of the 16:1 TDM serializer: tracks the slot index, assembles a
// frame in a shadow register and publishes it on Y with a one-cycle strobe.
module tdm_demux1_16 #(
  parameter int CH_W = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CH_W-1:0]    din,
  input  logic               din_valid,
  input  logic               frame_sync,
  output logic [16*CH_W-1:0] Y,
  output logic               frame_valid,
  output logic [3:0]         slot,
  output logic               locked,
  output logic               sync_err
);

  typedef enum logic {HUNT, RUN} state_t;

  state_t              state_q, state_d;
  logic [3:0]          slot_q, slot_d;
  logic [16*CH_W-1:0]  shadow_q, shadow_d;
  logic [16*CH_W-1:0]  y_q, y_d;
  logic                fv_q, fv_d;
  logic                serr_q, serr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      slot_q   <= '0;
      shadow_q <= '0;
      y_q      <= '0;
      fv_q     <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      fv_q     <= fv_d;
      serr_q   <= serr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    y_d      = y_q;
    fv_d     = 1'b0;
    serr_d   = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            shadow_d[0 +: CH_W] = din;
            slot_d              = 4'd1;
            state_d             = RUN;
          end
        end
        RUN: begin
          if (frame_sync && slot_q != 4'd0) begin
            // Early sync: throw away the partial frame and restart at slot 0.
            serr_d              = 1'b1;
            shadow_d            = '0;
            shadow_d[0 +: CH_W] = din;
            slot_d              = 4'd1;
          end else if (!frame_sync && slot_q == 4'd0) begin
            serr_d  = 1'b1;
            slot_d  = 4'd0;
            state_d = HUNT;
          end else if (slot_q == 4'd15) begin
            y_d    = {din, shadow_q[15*CH_W-1:0]};
            fv_d   = 1'b1;
            slot_d = 4'd0;
          end else begin
            shadow_d[slot_q*CH_W +: CH_W] = din;
            slot_d                        = slot_q + 4'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign Y           = y_q;
  assign frame_valid = fv_q;
  assign slot        = slot_q;
  assign locked      = (state_q == RUN);
  assign sync_err    = serr_q;

endmodule

// File: tb/tb_tdm_demux1_16.sv
// Directed bench for tdm_demux1_16: a CH_W=1 instance for framing behaviour and
// a CH_W=4 instance for wide-slot assembly.
module tb_tdm_demux1_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        din, dv, fs;
  logic [15:0] y;
  logic        fv, lk, se;
  logic [3:0]  sl;

  logic [3:0]  din4;
  logic        dv4, fs4;
  logic [63:0] y4;
  logic        fv4, lk4, se4;
  logic [3:0]  sl4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tdm_demux1_16 #(.CH_W(1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(dv), .frame_sync(fs),
    .Y(y), .frame_valid(fv), .slot(sl), .locked(lk), .sync_err(se)
  );

  tdm_demux1_16 #(.CH_W(4)) dut4 (
    .clk(clk), .rst(rst), .din(din4), .din_valid(dv4), .frame_sync(fs4),
    .Y(y4), .frame_valid(fv4), .slot(sl4), .locked(lk4), .sync_err(se4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic s, input logic d);
    dv = v; fs = s; din = d;
    @(posedge clk); #1;
  endtask

  task automatic step4(input logic v, input logic s, input logic [3:0] d);
    dv4 = v; fs4 = s; din4 = d;
    @(posedge clk); #1;
  endtask

  logic [15:0] pat;
  int          pulses;

  initial begin
    pat = 16'hD65A;  // bit k is the din for slot k
    rst = 1'b1; dv = 0; fs = 0; din = 0; dv4 = 0; fs4 = 0; din4 = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_Y", y, 0);
    chk("rst_slot", sl, 0);
    chk("rst_locked", lk, 0);
    chk("rst_fv", fv, 0);
    chk("rst_serr", se, 0);

    // 1: full-rate frame
    for (int k = 0; k < 16; k++) begin
      step(1, k == 0, pat[k]);
      chk("t1_slot", sl, (k + 1) % 16);
      chk("t1_fv", fv, k == 15);
      chk("t1_locked", lk, 1);
      if (k < 15) chk("t1_Y_hold", y, 0);
    end
    chk("t1_Y", y, 16'hD65A);
    step(0, 0, 0);
    chk("t1_fv_drop", fv, 0);
    chk("t1_Y_keep", y, 16'hD65A);

    // 2: same frame with gaps after slots 4 and 11 (reset first so Y is fresh)
    rst = 1'b1; step(0, 0, 0); rst = 1'b0;
    chk("t2_rst_Y", y, 0);
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      step(1, k == 0, pat[k]);
      if (fv) pulses++;
      if (k == 4 || k == 11) begin
        for (int g = 0; g < 3; g++) begin
          step(0, 1, ~pat[k]);
          if (fv) pulses++;
          chk("t2_gap_slot", sl, k + 1);
        end
      end
    end
    chk("t2_Y", y, 16'hD65A);
    for (int g = 0; g < 3; g++) begin
      step(0, 0, 0);
      if (fv) pulses++;
    end
    chk("t2_pulses", pulses, 1);

    // 3: early sync at slot 7
    for (int k = 0; k < 7; k++) step(1, k == 0, 0);
    chk("t3_pre_slot", sl, 7);
    step(1, 1, 1);
    chk("t3_serr", se, 1);
    chk("t3_slot", sl, 1);
    chk("t3_fv", fv, 0);
    chk("t3_Y_hold", y, 16'hD65A);
    for (int k = 1; k < 16; k++) begin
      step(1, 0, 1);
      if (k == 1) chk("t3_serr_drop", se, 0);
      if (k < 15) chk("t3_Y_hold2", y, 16'hD65A);
    end
    chk("t3_Y", y, 16'hFFFF);
    chk("t3_fv2", fv, 1);

    // 4: missing sync after a good frame
    step(1, 0, 0);
    chk("t4_serr", se, 1);
    chk("t4_locked", lk, 0);
    chk("t4_slot", sl, 0);
    chk("t4_Y_hold", y, 16'hFFFF);
    step(1, 0, 1);
    chk("t4_serr_drop", se, 0);
    chk("t4_hunt_slot", sl, 0);
    chk("t4_hunt_locked", lk, 0);
    for (int k = 0; k < 16; k++) begin
      step(1, k == 0, pat[k]);
      if (k == 0) chk("t4_relock", lk, 1);
    end
    chk("t4_Y", y, 16'hD65A);
    chk("t4_fv", fv, 1);

    // 5: reset at slot 9
    for (int k = 0; k < 9; k++) step(1, k == 0, 1);
    chk("t5_pre_slot", sl, 9);
    rst = 1'b1; step(1, 0, 1); rst = 1'b0;
    chk("t5_Y", y, 0);
    chk("t5_slot", sl, 0);
    chk("t5_locked", lk, 0);
    chk("t5_fv", fv, 0);
    pulses = 0;
    for (int k = 9; k < 16; k++) begin
      step(1, 0, 1);
      if (fv) pulses++;
    end
    chk("t5_ign_slot", sl, 0);
    chk("t5_ign_locked", lk, 0);
    chk("t5_ign_Y", y, 0);
    chk("t5_ign_pulses", pulses, 0);

    // 6: CH_W=4, slot k carries k
    chk("t6_rst_Y", y4, 0);
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      step4(1, k == 0, 4'(k));
      if (fv4) pulses++;
    end
    chk("t6_Y", y4, 64'hFEDCBA9876543210);
    step4(0, 0, 0);
    if (fv4) pulses++;
    chk("t6_pulses", pulses, 1);
    chk("t6_Y_keep", y4, 64'hFEDCBA9876543210);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
